// File: rtl/systolic_mmu_tile.sv
// -----------------------------------------------------------------------------
// systolic_mmu_tile
//   ROWS x COLS weight-stationary systolic matrix-multiply tile.
//   A weight matrix is loaded one row per beat. Activation vectors then stream
//   through an input skew, the PE array and an output deskew, so that all COLS
//   dot products of one vector emerge together. In stream mode every vector
//   yields one result beat. In accumulate mode results are summed per column
//   over the job and only the a_last vector yields a beat.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start, i_mode       job start pulse (honoured in IDLE); 0=stream, 1=accumulate
//   busy, done          not-IDLE flag; one-cycle pulse on DRAIN->IDLE
//   w_valid/w_ready     weight row beats, column j = w_data[j*W_W +: W_W]
//   a_valid/a_ready     activation beats, row i = a_data[i*A_W +: A_W], a_last
//   y_valid/y_ready     results, column j = y_data[j*ACC_W +: ACC_W]
//
// Build option
//   SATURATE_EN  defined: PE and accumulator adds saturate to the signed
//                ACC_W range; undefined: all adds wrap modulo 2^ACC_W.
// -----------------------------------------------------------------------------
module systolic_mmu_tile #(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int A_W   = 16,
    parameter int W_W   = 16,
    parameter int ACC_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  i_mode,
    output logic                  busy,
    output logic                  done,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [COLS*W_W-1:0]   w_data,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ROWS*A_W-1:0]   a_data,
    input  logic                  a_last,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic [COLS*ACC_W-1:0] y_data
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_COMPUTE, S_DRAIN} state_e;

    // Token depth: input register + ROWS+COLS-1 array/deskew stages.
    localparam int D     = ROWS + COLS;
    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    mode_q;
    logic                    stall, w_hs, a_hs, drain_ok;
    logic [D-1:0]            tok_v_q, tok_l_q;
    logic signed [W_W-1:0]   w_q    [ROWS][COLS];
    logic signed [A_W-1:0]   row_a  [ROWS];
    logic signed [A_W-1:0]   a_in   [ROWS][COLS];
    logic signed [ACC_W-1:0] p_in   [ROWS][COLS];
    logic signed [A_W-1:0]   pe_a_q [ROWS][COLS];
    logic signed [ACC_W-1:0] pe_p_q [ROWS][COLS];
    logic signed [ACC_W-1:0] res    [COLS];
    logic signed [ACC_W-1:0] acc_q  [COLS];
    logic signed [ACC_W-1:0] acc_sum[COLS];
    logic                    y_valid_q;
    logic [COLS*ACC_W-1:0]   y_data_q;

    function automatic logic signed [ACC_W-1:0] add_acc(input logic signed [ACC_W-1:0] x,
                                                        input logic signed [ACC_W-1:0] z);
        logic signed [ACC_W-1:0] s;
        s = x + z;
`ifdef SATURATE_EN
        // Overflow only when both operands share a sign the sum does not.
        if (x[ACC_W-1] == z[ACC_W-1] && s[ACC_W-1] != x[ACC_W-1])
            s = x[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
        return s;
    endfunction

    function automatic logic signed [ACC_W-1:0] mul(input logic signed [A_W-1:0] a,
                                                    input logic signed [W_W-1:0] w);
        logic signed [ACC_W-1:0] ae, we;
        ae = ACC_W'(a);
        we = ACC_W'(w);
        return ae * we;
    endfunction

    // The whole pipe freezes while a presented result is not taken.
    assign stall    = y_valid_q & ~y_ready;
    assign w_hs     = w_valid & w_ready;
    assign a_hs     = a_valid & a_ready;
    assign drain_ok = ~(|tok_v_q) & (~y_valid_q | y_ready);

    // ---------------- control FSM: state register ----------------
    // NOTE: sequential state is always updated with non-blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                cnt_q  <= '0;
                mode_q <= i_mode;
            end else if (w_hs) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // ---------------- control FSM: next state ----------------
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_LOAD_W;
            S_LOAD_W:  if (w_hs && cnt_q == CNT_W'(ROWS-1)) state_d = S_COMPUTE;
            S_COMPUTE: if (a_hs && a_last) state_d = S_DRAIN;
            S_DRAIN:   if (drain_ok) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // ---------------- control FSM: outputs ----------------
    always_comb begin
        busy    = (state_q != S_IDLE);
        w_ready = (state_q == S_LOAD_W);
        a_ready = (state_q == S_COMPUTE) & ~stall;
        done    = (state_q == S_DRAIN) & drain_ok;
    end

    // ---------------- weights ----------------
    // NOTE: array registers are reset explicitly because zeroed weights and pipe contents are part of the reset state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    w_q[i][j] <= '0;
        end else if (w_hs) begin
            for (int j = 0; j < COLS; j++)
                w_q[cnt_q][j] <= w_data[j*W_W +: W_W];
        end
    end

    // ---------------- token valid/last, aligned with the deskewed output ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tok_v_q <= '0;
            tok_l_q <= '0;
        end else if (!stall) begin
            tok_v_q <= {tok_v_q[D-2:0], a_hs};
            tok_l_q <= {tok_l_q[D-2:0], a_hs & a_last};
        end
    end

    // ---------------- input skew: row i sees its element i cycles later ----------------
    for (genvar i = 0; i < ROWS; i++) begin : g_skew
        logic signed [A_W-1:0] sk_q [i+1];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k <= i; k++) sk_q[k] <= '0;
            end else if (!stall) begin
                sk_q[0] <= a_hs ? a_data[i*A_W +: A_W] : '0;
                for (int k = 1; k <= i; k++) sk_q[k] <= sk_q[k-1];
            end
        end
        assign row_a[i] = sk_q[i];
    end

    // ---------------- PE array: activations flow right, psums flow down ----------------
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_in[i][j] = row_a[i];
            end else begin : g_a_pass
                assign a_in[i][j] = pe_a_q[i][j-1];
            end
            if (i == 0) begin : g_p_edge
                assign p_in[i][j] = '0;
            end else begin : g_p_pass
                assign p_in[i][j] = pe_p_q[i-1][j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    pe_a_q[i][j] <= '0;
                    pe_p_q[i][j] <= '0;
                end
        end else if (!stall) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    pe_a_q[i][j] <= a_in[i][j];
                    pe_p_q[i][j] <= add_acc(p_in[i][j], mul(a_in[i][j], w_q[i][j]));
                end
        end
    end

    // ---------------- output deskew: column j delayed COLS-1-j cycles ----------------
    for (genvar j = 0; j < COLS; j++) begin : g_deskew
        localparam int DJ = COLS - 1 - j;
        if (DJ == 0) begin : g_direct
            assign res[j] = pe_p_q[ROWS-1][j];
        end else begin : g_delay
            logic signed [ACC_W-1:0] ds_q [DJ];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < DJ; k++) ds_q[k] <= '0;
                end else if (!stall) begin
                    ds_q[0] <= pe_p_q[ROWS-1][j];
                    for (int k = 1; k < DJ; k++) ds_q[k] <= ds_q[k-1];
                end
            end
            assign res[j] = ds_q[DJ-1];
        end
        assign acc_sum[j] = add_acc(acc_q[j], res[j]);
    end

    // ---------------- result register and per-column accumulators ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            for (int j = 0; j < COLS; j++) acc_q[j] <= '0;
        end else begin
            if (!stall) begin
                y_valid_q <= tok_v_q[D-1] & (~mode_q | tok_l_q[D-1]);
                if (tok_v_q[D-1]) begin
                    for (int j = 0; j < COLS; j++) begin
                        if (!mode_q) begin
                            y_data_q[j*ACC_W +: ACC_W] <= res[j];
                        end else if (tok_l_q[D-1]) begin
                            y_data_q[j*ACC_W +: ACC_W] <= acc_sum[j];
                            acc_q[j]                   <= '0;
                        end else begin
                            acc_q[j] <= acc_sum[j];
                        end
                    end
                end
            end
            // A new job always starts from empty accumulators.
            if (state_q == S_IDLE && start)
                for (int j = 0; j < COLS; j++) acc_q[j] <= '0;
        end
    end

    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;

endmodule
